nb_iter_ctrl_mc: RTL and testbench
==================================

Name: nb_iter_ctrl_mc

Overview:
- Parametrised successor iteration controller for the NB-LDPC decoder.
- Sequences alternating variable-node (VN) and check-node (CN) passes across N_VNU/N_CNU processing units. Collects per-unit finish flags, which may arrive staggered, into sticky masks.
- Supports syndrome-based early termination, a ping-pong channel-LLR bank select, an output handshake, and a per-phase watchdog.
- Sits between the input LLR buffer/loader and the VNU/CNU arrays.

Parameters:
- N_VNU, 10, number of variable-node units (width of finish_vn).
- N_CNU, 5, number of check-node units (width of finish_cn).
- IW, 7, width of max_iter_num and iter_num.
- TW, 12, width of watchdog counter.
- TIMEOUT, 4000, max cycles per phase before abort (must be < 2^TW).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- data_ready  in  1  level; a loaded frame is available in the bank selected by rd_addr_high_Lch.
- data_ack  out  1  1-cycle pulse: frame accepted.
- max_iter_num  in  IW  iteration limit, sampled at frame accept; 0 treated as 1.
- early_term_en  in  1  enables syndrome early stop, sampled at frame accept.
- syndrome_ok  in  1  all checks satisfied; sampled in the cycle CN completion is detected.
- finish_vn  in  N_VNU  per-VNU done pulses/levels.
- finish_cn  in  N_CNU  per-CNU done pulses/levels.
- out_ack  in  1  downstream has taken the decoded result.
- rd_addr_high_Lch  out  1  LLR ping-pong bank select for the frame being decoded.
- value_start  out  1  1-cycle VN pass start pulse.
- check_start  out  1  1-cycle CN pass start pulse.
- first_iter_flag  out  1  high throughout iteration 1 (VN and CN phases).
- iter_num  out  IW  current iteration, 1-based; holds final value after termination.
- Mux_result  out  1  selects decoded hard-decision path; high in DONE.
- output_ready  out  1  level; result valid until out_ack.
- early_stop  out  1  valid with output_ready: terminated by syndrome.
- timeout_err  out  1  valid with output_ready: phase watchdog expired.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: state IDLE; all outputs 0; iter_num = 0; rd_addr_high_Lch = 0; masks and counters cleared. Reset in any state, mid-frame included, aborts immediately with no output_ready.
- States: IDLE, VN_RUN, CN_RUN, DONE. All outputs are registered.
- IDLE:
  - data_ready = 1 at edge k → in cycle k+1: state VN_RUN, value_start = 1, data_ack = 1, first_iter_flag = 1, iter_num = 1.
  - At the same edge, max_iter_num and early_term_en are latched.
- VN_RUN:
  - vn_mask is cleared in the value_start cycle.
  - From the cycle after value_start: vn_mask |= finish_vn. Finish bits in the start cycle itself are ignored.
  - Completion is detected when (vn_mask | finish_vn) is all ones → next cycle: CN_RUN, check_start = 1.
  - finish_cn is ignored in this state.
- CN_RUN:
  - Same mask rule using cn_mask and finish_cn; finish_vn is ignored.
  - On completion edge, if early_term_en & syndrome_ok → DONE, early_stop = 1.
  - Else if iter_num >= latched max → DONE.
  - Else → VN_RUN with value_start = 1 next cycle, iter_num += 1, first_iter_flag = 0.
  - Gap from last CN finish to the next value_start is exactly 1 cycle.
- Watchdog:
  - Counter is cleared on each start pulse and increments each cycle in VN_RUN/CN_RUN.
  - Reaching TIMEOUT → DONE with timeout_err = 1, iter_num held. Timeout takes priority over completion in the same cycle.
- DONE:
  - output_ready = 1 and Mux_result = 1 until out_ack is sampled high.
  - Then at that edge: IDLE, rd_addr_high_Lch toggles, early_stop/timeout_err cleared. The next frame is read from the other bank.
  - out_ack outside DONE is ignored.
  - data_ready while busy is ignored and not queued; it is serviced when IDLE is re-entered, no earlier than 1 cycle after out_ack.
- iter_num never exceeds the latched max; no wrap-around, IW bits suffice.

Test Plan:
- Defaults, max_iter_num = 3, early_term_en = 0; all finish_vn asserted 100 cycles after each value_start, finish_cn likewise → exactly 3 value_start and 3 check_start pulses; iter_num 1, 2, 3; first_iter_flag only during iteration 1; output_ready 1 cycle after the 3rd CN finish; early_stop = 0.
- max = 20, early_term_en = 1, syndrome_ok = 1 only at iteration 2 CN completion → DONE with iter_num = 2, early_stop = 1, 2 check_start pulses total.
- Staggered finishes: VNU bits 0..9 pulsed one per cycle, single-cycle each, plus one bit pulsed in the value_start cycle → that bit is ignored; check_start only after it is re-pulsed, 1 cycle after the last mask bit.
- TIMEOUT = 50, finish_cn[4] never asserted → DONE 50 cycles after check_start, timeout_err = 1, iter_num held at 1.
- Two back-to-back frames with data_ready held high: rd_addr_high_Lch 0 for frame 1, 1 for frame 2; data_ack once per frame; second value_start no earlier than 1 cycle after out_ack; max_iter_num = 0 runs one iteration.
- reset = 0 for one cycle during CN_RUN of iteration 2 → all outputs 0, iter_num = 0, no output_ready; next data_ready starts cleanly with bank 0.

Source files
------------

// File: rtl/nb_iter_ctrl_mc_if.sv
// Signal bundle between the NB-LDPC iteration controller and the loader, VNU/CNU arrays and result sink.
// The master modport is the controller side; the slave modport is everything around it.
interface nb_iter_ctrl_mc_if #(
    parameter int N_VNU = 10,
    parameter int N_CNU = 5,
    parameter int IW    = 7
);
    logic             data_ready;
    logic             data_ack;
    logic [IW-1:0]    max_iter_num;
    logic             early_term_en;
    logic             syndrome_ok;
    logic [N_VNU-1:0] finish_vn;
    logic [N_CNU-1:0] finish_cn;
    logic             out_ack;
    logic             rd_addr_high_Lch;
    logic             value_start;
    logic             check_start;
    logic             first_iter_flag;
    logic [IW-1:0]    iter_num;
    logic             Mux_result;
    logic             output_ready;
    logic             early_stop;
    logic             timeout_err;
    logic             busy;

    modport master (
        input  data_ready, max_iter_num, early_term_en, syndrome_ok,
               finish_vn, finish_cn, out_ack,
        output data_ack, rd_addr_high_Lch, value_start, check_start,
               first_iter_flag, iter_num, Mux_result, output_ready,
               early_stop, timeout_err, busy
    );

    modport slave (
        output data_ready, max_iter_num, early_term_en, syndrome_ok,
               finish_vn, finish_cn, out_ack,
        input  data_ack, rd_addr_high_Lch, value_start, check_start,
               first_iter_flag, iter_num, Mux_result, output_ready,
               early_stop, timeout_err, busy
    );
endinterface

// File: rtl/nb_iter_ctrl_mc.sv
// NB-LDPC iteration controller: alternates VN and CN passes, gathers staggered unit finish flags,
// handles syndrome early stop, per-phase watchdog, ping-pong LLR bank select and result handshake.
module nb_iter_ctrl_mc #(
    parameter int N_VNU   = 10,
    parameter int N_CNU   = 5,
    parameter int IW      = 7,
    parameter int TW      = 12,
    parameter int TIMEOUT = 4000
) (
    input  logic              clk,
    input  logic              reset,
    nb_iter_ctrl_mc_if.master bus
);
    typedef enum logic [1:0] {IDLE, VN_RUN, CN_RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    iter_q, iter_d;
    logic [IW-1:0]    max_q, max_d;
    logic             et_en_q, et_en_d;
    logic [N_VNU-1:0] vn_mask_q, vn_mask_d;
    logic [N_CNU-1:0] cn_mask_q, cn_mask_d;
    logic [TW-1:0]    wd_q, wd_d;
    logic             bank_q, bank_d;
    logic             value_start_q, value_start_d;
    logic             check_start_q, check_start_d;
    logic             data_ack_q, data_ack_d;
    logic             first_iter_q, first_iter_d;
    logic             output_ready_q, output_ready_d;
    logic             mux_q, mux_d;
    logic             early_stop_q, early_stop_d;
    logic             timeout_err_q, timeout_err_d;
    logic             busy_q, busy_d;

    logic vn_all, cn_all, wd_expired;

    // The current-cycle flags are OR-ed in so the last finish bit completes the phase without extra latency.
    assign vn_all     = &(vn_mask_q | bus.finish_vn);
    assign cn_all     = &(cn_mask_q | bus.finish_cn);
    assign wd_expired = (wd_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        iter_d        = iter_q;
        max_d         = max_q;
        et_en_d       = et_en_q;
        vn_mask_d     = vn_mask_q;
        cn_mask_d     = cn_mask_q;
        wd_d          = wd_q;
        bank_d        = bank_q;
        value_start_d = 1'b0;
        check_start_d = 1'b0;
        data_ack_d    = 1'b0;
        first_iter_d  = first_iter_q;
        early_stop_d  = early_stop_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.data_ready) begin
                    state_d       = VN_RUN;
                    value_start_d = 1'b1;
                    data_ack_d    = 1'b1;
                    first_iter_d  = 1'b1;
                    iter_d        = IW'(1);
                    max_d         = (bus.max_iter_num == '0) ? IW'(1) : bus.max_iter_num;
                    et_en_d       = bus.early_term_en;
                    vn_mask_d     = '0;
                    cn_mask_d     = '0;
                    wd_d          = '0;
                end
            end

            VN_RUN: begin
                wd_d = wd_q + 1'b1;
                if (!value_start_q) begin
                    vn_mask_d = vn_mask_q | bus.finish_vn;
                end
                if (wd_expired) begin
                    state_d       = DONE;
                    timeout_err_d = 1'b1;
                    first_iter_d  = 1'b0;
                end else if (!value_start_q && vn_all) begin
                    state_d       = CN_RUN;
                    check_start_d = 1'b1;
                    cn_mask_d     = '0;
                    wd_d          = '0;
                end
            end

            CN_RUN: begin
                wd_d = wd_q + 1'b1;
                if (!check_start_q) begin
                    cn_mask_d = cn_mask_q | bus.finish_cn;
                end
                if (wd_expired) begin
                    state_d       = DONE;
                    timeout_err_d = 1'b1;
                    first_iter_d  = 1'b0;
                end else if (!check_start_q && cn_all) begin
                    if (et_en_q && bus.syndrome_ok) begin
                        state_d      = DONE;
                        early_stop_d = 1'b1;
                        first_iter_d = 1'b0;
                    end else if (iter_q >= max_q) begin
                        state_d      = DONE;
                        first_iter_d = 1'b0;
                    end else begin
                        state_d       = VN_RUN;
                        value_start_d = 1'b1;
                        iter_d        = iter_q + 1'b1;
                        first_iter_d  = 1'b0;
                        vn_mask_d     = '0;
                        wd_d          = '0;
                    end
                end
            end

            DONE: begin
                // Releasing the result hands the consumed bank back to the loader.
                if (bus.out_ack) begin
                    state_d       = IDLE;
                    bank_d        = ~bank_q;
                    early_stop_d  = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase

        output_ready_d = (state_d == DONE);
        mux_d          = (state_d == DONE);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            iter_q         <= '0;
            max_q          <= '0;
            et_en_q        <= 1'b0;
            vn_mask_q      <= '0;
            cn_mask_q      <= '0;
            wd_q           <= '0;
            bank_q         <= 1'b0;
            value_start_q  <= 1'b0;
            check_start_q  <= 1'b0;
            data_ack_q     <= 1'b0;
            first_iter_q   <= 1'b0;
            output_ready_q <= 1'b0;
            mux_q          <= 1'b0;
            early_stop_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            iter_q         <= iter_d;
            max_q          <= max_d;
            et_en_q        <= et_en_d;
            vn_mask_q      <= vn_mask_d;
            cn_mask_q      <= cn_mask_d;
            wd_q           <= wd_d;
            bank_q         <= bank_d;
            value_start_q  <= value_start_d;
            check_start_q  <= check_start_d;
            data_ack_q     <= data_ack_d;
            first_iter_q   <= first_iter_d;
            output_ready_q <= output_ready_d;
            mux_q          <= mux_d;
            early_stop_q   <= early_stop_d;
            timeout_err_q  <= timeout_err_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.data_ack         = data_ack_q;
    assign bus.rd_addr_high_Lch = bank_q;
    assign bus.value_start      = value_start_q;
    assign bus.check_start      = check_start_q;
    assign bus.first_iter_flag  = first_iter_q;
    assign bus.iter_num         = iter_q;
    assign bus.Mux_result       = mux_q;
    assign bus.output_ready     = output_ready_q;
    assign bus.early_stop       = early_stop_q;
    assign bus.timeout_err      = timeout_err_q;
    assign bus.busy             = busy_q;
endmodule

// File: tb/tb_nb_iter_ctrl_mc.sv
// Scoreboard bench for nb_iter_ctrl_mc: a default instance for the iteration flows and a
// short-watchdog instance for the timeout path.
module tb_nb_iter_ctrl_mc;
    localparam int N_VNU = 10;
    localparam int N_CNU = 5;
    localparam int IW    = 7;

    typedef struct {
        int iter;
        int early;
        int tmo;
        int bank;
    } exp_t;

    logic clk;
    logic reset;

    nb_iter_ctrl_mc_if #(.N_VNU(N_VNU), .N_CNU(N_CNU), .IW(IW)) bus ();
    nb_iter_ctrl_mc_if #(.N_VNU(N_VNU), .N_CNU(N_CNU), .IW(IW)) bus_to ();

    nb_iter_ctrl_mc #(.N_VNU(N_VNU), .N_CNU(N_CNU), .IW(IW), .TW(12), .TIMEOUT(4000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    nb_iter_ctrl_mc #(.N_VNU(N_VNU), .N_CNU(N_CNU), .IW(IW), .TW(12), .TIMEOUT(50)) dut_to (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    // Finish flags come from the auto-responder unless a test takes them over by hand.
    logic             auto_en;
    logic [N_VNU-1:0] auto_vn, man_vn;
    logic [N_CNU-1:0] auto_cn, man_cn;
    logic             auto_synd;
    int               synd_iter;
    int               tb_bank;

    assign bus.finish_vn   = auto_en ? auto_vn : man_vn;
    assign bus.finish_cn   = auto_en ? auto_cn : man_cn;
    assign bus.syndrome_ok = auto_synd;

    int cyc = 0, n_vs = 0, n_cs = 0, n_ack = 0, n_or = 0;
    int model_iter = 0, vn_cnt = 0, cn_cnt = 0, vn_fin_cyc = 0, cn_fin_cyc = 0;
    int vn_delay = 100, cn_delay = 100;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    initial begin : monitor
        logic prev_or;
        exp_t e;
        prev_or   = 1'b0;
        auto_vn   = '0;
        auto_cn   = '0;
        auto_synd = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.data_ack === 1'b1) n_ack++;
            if (bus.value_start === 1'b1) begin
                n_vs++;
                if (bus.data_ack === 1'b1) model_iter = 1;
                else begin
                    model_iter++;
                    if (auto_en) checkOutput("vs_gap", cyc - cn_fin_cyc, 1);
                end
                checkOutput("iter_num", int'(bus.iter_num), model_iter);
                checkOutput("first_iter_vs", int'(bus.first_iter_flag), int'(model_iter == 1));
                if (auto_en) vn_cnt = vn_delay;
            end
            if (bus.check_start === 1'b1) begin
                n_cs++;
                checkOutput("first_iter_cs", int'(bus.first_iter_flag), int'(model_iter == 1));
                if (auto_en) begin
                    checkOutput("cs_gap", cyc - vn_fin_cyc, 1);
                    cn_cnt = cn_delay;
                end
            end
            if (bus.output_ready === 1'b1 && !prev_or) begin
                n_or++;
                if (sb_q.size() == 0) checkOutput("sb_unexpected", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    checkOutput("sb_iter", int'(bus.iter_num), e.iter);
                    checkOutput("sb_early", int'(bus.early_stop), e.early);
                    checkOutput("sb_tmo", int'(bus.timeout_err), e.tmo);
                    checkOutput("sb_bank", int'(bus.rd_addr_high_Lch), e.bank);
                    if (auto_en) checkOutput("done_lat", cyc - cn_fin_cyc, 1);
                end
            end
            prev_or = (bus.output_ready === 1'b1);

            if (bus.busy !== 1'b1) begin
                vn_cnt = 0;
                cn_cnt = 0;
            end
            auto_vn   = '0;
            auto_cn   = '0;
            auto_synd = 1'b0;
            if (auto_en) begin
                if (vn_cnt > 0) begin
                    vn_cnt--;
                    if (vn_cnt == 0) begin
                        auto_vn    = '1;
                        vn_fin_cyc = cyc;
                    end
                end
                if (cn_cnt > 0) begin
                    cn_cnt--;
                    if (cn_cnt == 0) begin
                        auto_cn    = '1;
                        auto_synd  = (model_iter == synd_iter);
                        cn_fin_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic waitAck();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (bus.data_ack !== 1'b1 && g < 20);
        checkOutput("ack_seen", int'(bus.data_ack === 1'b1), 1);
    endtask

    task automatic waitDone();
        int g = 0;
        while (bus.output_ready !== 1'b1 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        checkOutput("done_seen", int'(bus.output_ready === 1'b1), 1);
        checkOutput("mux_result", int'(bus.Mux_result), 1);
    endtask

    task automatic releaseResult();
        repeat (2) @(negedge clk);
        bus.out_ack = 1'b1;
        @(negedge clk);
        bus.out_ack = 1'b0;
        tb_bank ^= 1;
        checkOutput("or_cleared", int'(bus.output_ready), 0);
        checkOutput("bank_toggle", int'(bus.rd_addr_high_Lch), tb_bank);
        checkOutput("early_cleared", int'(bus.early_stop), 0);
        checkOutput("busy_idle", int'(bus.busy), 0);
    endtask

    // One full auto-responded frame; a stray out_ack mid-run must be ignored.
    task automatic applyStimulus(input int max_it, input int et, input int synd_it);
        bus.max_iter_num  = IW'(max_it);
        bus.early_term_en = et[0];
        synd_iter         = synd_it;
        bus.data_ready    = 1'b1;
        waitAck();
        bus.data_ready = 1'b0;
        bus.out_ack    = 1'b1;
        @(negedge clk);
        bus.out_ack = 1'b0;
        waitDone();
        releaseResult();
        @(negedge clk);
    endtask

    initial begin : main
        int base_vs, base_cs, base_ack, base_or, g, gap;
        reset              = 1'b0;
        auto_en            = 1'b1;
        man_vn             = '0;
        man_cn             = '0;
        synd_iter          = 0;
        tb_bank            = 0;
        bus.data_ready     = 1'b0;
        bus.max_iter_num   = '0;
        bus.early_term_en  = 1'b0;
        bus.out_ack        = 1'b0;
        bus_to.data_ready  = 1'b0;
        bus_to.max_iter_num = '0;
        bus_to.early_term_en = 1'b0;
        bus_to.syndrome_ok = 1'b0;
        bus_to.finish_vn   = '0;
        bus_to.finish_cn   = '0;
        bus_to.out_ack     = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_iter", int'(bus.iter_num), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_or", int'(bus.output_ready), 0);
        checkOutput("rst_vs", int'(bus.value_start), 0);
        checkOutput("rst_bank", int'(bus.rd_addr_high_Lch), 0);
        checkOutput("rst_mux", int'(bus.Mux_result), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] full run, max 3 iterations");
        base_vs = n_vs; base_cs = n_cs; base_ack = n_ack;
        sb_q.push_back('{iter: 3, early: 0, tmo: 0, bank: tb_bank});
        applyStimulus(3, 0, 0);
        checkOutput("t1_vs_count", n_vs - base_vs, 3);
        checkOutput("t1_cs_count", n_cs - base_cs, 3);
        checkOutput("t1_ack_count", n_ack - base_ack, 1);

        $display("[TB] syndrome early stop at iteration 2");
        base_cs = n_cs;
        sb_q.push_back('{iter: 2, early: 1, tmo: 0, bank: tb_bank});
        applyStimulus(20, 1, 2);
        checkOutput("t2_cs_count", n_cs - base_cs, 2);
        synd_iter = 0;

        $display("[TB] reset during CN pass of iteration 2");
        base_or = n_or;
        bus.max_iter_num = IW'(5);
        bus.early_term_en = 1'b0;
        bus.data_ready = 1'b1;
        waitAck();
        bus.data_ready = 1'b0;
        g = 0;
        while (!(bus.check_start === 1'b1 && bus.iter_num == IW'(2)) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        checkOutput("rst_mid_reached", int'(bus.check_start === 1'b1), 1);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("rst_mid_iter", int'(bus.iter_num), 0);
        checkOutput("rst_mid_busy", int'(bus.busy), 0);
        checkOutput("rst_mid_first", int'(bus.first_iter_flag), 0);
        checkOutput("rst_mid_bank", int'(bus.rd_addr_high_Lch), 0);
        repeat (300) @(negedge clk);
        checkOutput("rst_mid_no_or", n_or - base_or, 0);
        tb_bank = 0;

        $display("[TB] back-to-back frames, data_ready held, max 0");
        base_ack = n_ack;
        sb_q.push_back('{iter: 1, early: 0, tmo: 0, bank: tb_bank});
        sb_q.push_back('{iter: 1, early: 0, tmo: 0, bank: tb_bank ^ 1});
        bus.max_iter_num = '0;
        bus.data_ready = 1'b1;
        waitDone();
        bus.out_ack = 1'b1;
        @(negedge clk);
        bus.out_ack = 1'b0;
        tb_bank ^= 1;
        gap = 1;
        while (bus.value_start !== 1'b1 && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        checkOutput("b2b_gap", gap, 2);
        checkOutput("b2b_bank2", int'(bus.rd_addr_high_Lch), tb_bank);
        bus.data_ready = 1'b0;
        waitDone();
        releaseResult();
        checkOutput("b2b_ack_count", n_ack - base_ack, 2);
        @(negedge clk);

        $display("[TB] staggered VN finishes with one bit in the start cycle");
        man_vn  = '0;
        man_cn  = '0;
        auto_en = 1'b0;
        sb_q.push_back('{iter: 1, early: 0, tmo: 0, bank: tb_bank});
        bus.max_iter_num = IW'(1);
        bus.data_ready = 1'b1;
        waitAck();
        bus.data_ready = 1'b0;
        man_vn[3] = 1'b1;
        base_cs = n_cs;
        for (int i = 0; i < N_VNU; i++) begin
            if (i != 3) begin
                @(negedge clk);
                man_vn    = '0;
                man_vn[i] = 1'b1;
            end
        end
        @(negedge clk);
        man_vn = '0;
        repeat (3) @(negedge clk);
        checkOutput("stag_no_cs", n_cs - base_cs, 0);
        man_vn[3] = 1'b1;
        @(negedge clk);
        man_vn = '0;
        checkOutput("stag_cs", int'(bus.check_start), 1);
        @(negedge clk);
        man_cn = '1;
        @(negedge clk);
        man_cn = '0;
        checkOutput("stag_done", int'(bus.output_ready), 1);
        releaseResult();
        auto_en = 1'b1;

        $display("[TB] watchdog instance, CNU 4 never finishes");
        bus_to.max_iter_num = IW'(3);
        bus_to.data_ready = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (bus_to.data_ack !== 1'b1 && g < 20);
        checkOutput("to_ack", int'(bus_to.data_ack === 1'b1), 1);
        bus_to.data_ready = 1'b0;
        repeat (4) @(negedge clk);
        bus_to.finish_vn = '1;
        @(negedge clk);
        bus_to.finish_vn = '0;
        checkOutput("to_cs", int'(bus_to.check_start), 1);
        bus_to.finish_cn = 5'b01111;
        gap = 0;
        while (bus_to.output_ready !== 1'b1 && gap < 200) begin
            @(negedge clk);
            gap++;
            if (gap == 3) bus_to.finish_cn = '0;
        end
        checkOutput("to_latency", gap, 50);
        checkOutput("to_err", int'(bus_to.timeout_err), 1);
        checkOutput("to_iter", int'(bus_to.iter_num), 1);
        checkOutput("to_early", int'(bus_to.early_stop), 0);
        bus_to.out_ack = 1'b1;
        @(negedge clk);
        bus_to.out_ack = 1'b0;
        checkOutput("to_err_cleared", int'(bus_to.timeout_err), 0);
        checkOutput("to_bank", int'(bus_to.rd_addr_high_Lch), 1);

        repeat (2) @(negedge clk);
        checkOutput("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : global_guard
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] run aborted");
    end
endmodule
